hazard_detection_unit: RTL and testbench

- Producer-side companion to the EX-stage forwarding logic in the 5-stage MIPS pipeline.
- Decides when the pipeline must stall (PC and IF/ID held, bubble into ID/EX) and when IF/ID is flushed after a branch or jump resolved in ID.
- Supplies ID-stage bypass selects for the branch comparator.
- Sequential part: a 2-state stall FSM for 2-cycle load→branch hazards and a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_pkg.sv | 6 +
 rtl/hazard_detection_unit_if.sv | 21 ++
 rtl/stall_counter.sv | 14 +
 rtl/hazard_detection_unit.sv | 43 ++++
 tb/tb_hazard_detection_unit.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline widths and encodings for hazard detection and EX forwarding
package pipeline_pkg;
    localparam int REG_ADDR_W = 5;
    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} hdu_state_t;
    typedef enum logic [1:0] {FWD_NONE = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10} fwd_sel_t;
endpackage

// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if: ID/EX/MEM hazard inputs and stall/flush/bypass outputs
interface hazard_detection_unit_if #(
    parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
    parameter int CNT_W = 32
);
    logic [REG_ADDR_W-1:0] IDRegisterRs, IDRegisterRt, EX_WriteReg, MEM_WriteReg;
    logic IDUsesRs, IDUsesRt, IDBranch, IDJump, BranchTaken;
    logic EXMemRead, EXRegWrite, MEMMemRead, MEMRegWrite;
    logic PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, ForwardC, ForwardD;
    logic [CNT_W-1:0] StallCycles;
    modport master (
        output IDRegisterRs, IDRegisterRt, IDUsesRs, IDUsesRt, IDBranch, IDJump, BranchTaken,
               EXMemRead, EXRegWrite, EX_WriteReg, MEMMemRead, MEMRegWrite, MEM_WriteReg,
        input  PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, ForwardC, ForwardD, StallCycles
    );
    modport slave (
        input  IDRegisterRs, IDRegisterRt, IDUsesRs, IDUsesRt, IDBranch, IDJump, BranchTaken,
               EXMemRead, EXRegWrite, EX_WriteReg, MEMMemRead, MEMRegWrite, MEM_WriteReg,
        output PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, ForwardC, ForwardD, StallCycles
    );
endinterface

// File: rtl/stall_counter.sv
// stall_counter: saturating up-counter with synchronous active-low clear
module stall_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;
    always_comb count_d = (en && count_q != '1) ? count_q + CNT_W'(1) : count_q;
    always_ff @(posedge clk) count_q <= !rst_n ? '0 : count_d;
    assign count = count_q;
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: stall/flush control and ID branch bypass selects for the 5-stage pipeline
module hazard_detection_unit #(
    parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst_n,
    hazard_detection_unit_if.slave hz
);
    import pipeline_pkg::*;
    hdu_state_t state_q, state_d;
    logic ex_nz, mem_nz, m_ex, m_mem, h_lu, h_ba, h_bl2, h_bl1, stall;
    always_comb begin
        ex_nz  = hz.EX_WriteReg != REG_ADDR_W'(0);
        mem_nz = hz.MEM_WriteReg != REG_ADDR_W'(0);
        m_ex   = ex_nz && ((hz.IDUsesRs && hz.EX_WriteReg == hz.IDRegisterRs) ||
                           (hz.IDUsesRt && hz.EX_WriteReg == hz.IDRegisterRt));
        m_mem  = mem_nz && ((hz.IDUsesRs && hz.MEM_WriteReg == hz.IDRegisterRs) ||
                            (hz.IDUsesRt && hz.MEM_WriteReg == hz.IDRegisterRt));
        h_lu   = hz.EXMemRead && m_ex;
        h_ba   = hz.IDBranch && hz.EXRegWrite && !hz.EXMemRead && m_ex;
        h_bl2  = hz.IDBranch && hz.EXMemRead && m_ex;
        h_bl1  = hz.IDBranch && hz.MEMMemRead && m_mem;
        stall  = state_q == HOLD || h_lu || h_ba || h_bl2 || h_bl1;
        // HOLD covers the second cycle of a load feeding a branch, regardless of inputs
        state_d = (state_q == RUN && h_bl2) ? HOLD : RUN;
        hz.PCWrite   = !rst_n || !stall;
        hz.IFIDWrite = !rst_n || !stall;
        hz.IDEXFlush = !rst_n || stall;
        hz.IFIDFlush = !rst_n || (!stall && (hz.IDJump || (hz.IDBranch && hz.BranchTaken)));
        hz.ForwardC  = rst_n && hz.IDBranch && hz.MEMRegWrite && !hz.MEMMemRead && mem_nz &&
                       hz.MEM_WriteReg == hz.IDRegisterRs;
        hz.ForwardD  = rst_n && hz.IDBranch && hz.MEMRegWrite && !hz.MEMMemRead && mem_nz &&
                       hz.MEM_WriteReg == hz.IDRegisterRt;
    end
    always_ff @(posedge clk) state_q <= !rst_n ? RUN : state_d;
    stall_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .en(stall),
        .count(hz.StallCycles)
    );
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed and random stimulus against a stall-budget reference model
module tb_hazard_detection_unit;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    typedef struct {
        logic rst_n;
        logic [AW-1:0] rs, rt, exd, memd;
        logic urs, urt, br, jp, tk, exr, exw, memr, memw;
    } stim_t;
    typedef struct {
        logic pcw, ifidw, idexf, ifidf, fc, fd;
        int cnt;
    } exp_t;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;
    hazard_detection_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hz ();
    hazard_detection_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hz(hz.slave)
    );
    exp_t q[$];
    exp_t m;
    int extra = 0;
    int cnt = 0;
    int checks = 0;
    int errors = 0;
    task automatic chk(input string n, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, want);
        end
    endtask
    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1; s.rs = 0; s.rt = 0; s.exd = 0; s.memd = 0;
        s.urs = 0; s.urt = 0; s.br = 0; s.jp = 0; s.tk = 0;
        s.exr = 0; s.exw = 0; s.memr = 0; s.memw = 0;
        return s;
    endfunction
    // Reference model: 'extra' is the number of forced stall cycles still owed by a load->branch.
    task automatic step(input stim_t s);
        exp_t e;
        logic mex, mmem, hlu, hba, hbl2, hbl1, st;
        @(posedge clk);
        #1;
        rst_n = s.rst_n;
        hz.IDRegisterRs = s.rs; hz.IDRegisterRt = s.rt; hz.IDUsesRs = s.urs; hz.IDUsesRt = s.urt;
        hz.IDBranch = s.br; hz.IDJump = s.jp; hz.BranchTaken = s.tk;
        hz.EXMemRead = s.exr; hz.EXRegWrite = s.exw; hz.EX_WriteReg = s.exd;
        hz.MEMMemRead = s.memr; hz.MEMRegWrite = s.memw; hz.MEM_WriteReg = s.memd;
        mex  = s.exd != 0 && ((s.urs && s.exd == s.rs) || (s.urt && s.exd == s.rt));
        mmem = s.memd != 0 && ((s.urs && s.memd == s.rs) || (s.urt && s.memd == s.rt));
        hlu  = s.exr && mex;
        hba  = s.br && s.exw && !s.exr && mex;
        hbl2 = s.br && s.exr && mex;
        hbl1 = s.br && s.memr && mmem;
        st   = extra > 0 || hlu || hba || hbl2 || hbl1;
        e.cnt = cnt;
        if (!s.rst_n) begin
            e.pcw = 1; e.ifidw = 1; e.idexf = 1; e.ifidf = 1; e.fc = 0; e.fd = 0;
            extra = 0;
            cnt = 0;
        end else begin
            e.pcw = !st; e.ifidw = !st; e.idexf = st;
            e.ifidf = !st && (s.jp || (s.br && s.tk));
            e.fc = s.br && s.memw && !s.memr && s.memd != 0 && s.memd == s.rs;
            e.fd = s.br && s.memw && !s.memr && s.memd != 0 && s.memd == s.rt;
            if (st && cnt < CMAX) cnt++;
            extra = extra > 0 ? extra - 1 : (hbl2 ? 1 : 0);
        end
        q.push_back(e);
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("PCWrite", int'(hz.PCWrite), int'(m.pcw));
            chk("IFIDWrite", int'(hz.IFIDWrite), int'(m.ifidw));
            chk("IDEXFlush", int'(hz.IDEXFlush), int'(m.idexf));
            chk("IFIDFlush", int'(hz.IFIDFlush), int'(m.ifidf));
            chk("ForwardC", int'(hz.ForwardC), int'(m.fc));
            chk("ForwardD", int'(hz.ForwardD), int'(m.fd));
            chk("StallCycles", int'(hz.StallCycles), m.cnt);
        end
    end
    initial begin
        stim_t s;
        int w;
        s = idle(); s.rst_n = 0;
        step(s); step(s);
        s = idle(); s.exr = 1; s.exw = 1; s.exd = 8; s.rs = 8; s.urs = 1;
        step(s);
        s = idle(); s.rs = 8; s.urs = 1; s.memr = 1; s.memw = 1; s.memd = 8;
        step(s);
        s = idle(); s.exw = 1; s.exd = 9; s.br = 1; s.rs = 9; s.urs = 1;
        step(s);
        s = idle(); s.memw = 1; s.memd = 9; s.br = 1; s.rs = 9; s.urs = 1; s.tk = 1;
        step(s);
        s = idle(); s.exr = 1; s.exw = 1; s.exd = 10; s.br = 1; s.rt = 10; s.urt = 1;
        step(s);
        s = idle(); step(s); step(s);
        s = idle(); s.exr = 1; s.exd = 0; s.rs = 0; s.urs = 1;
        step(s);
        s = idle(); s.exr = 1; s.exd = 8; s.rt = 8; s.urt = 0;
        step(s);
        s = idle(); s.exr = 1; s.exd = 8; s.rs = 8; s.urs = 1; s.jp = 1;
        step(s);
        s = idle(); s.jp = 1; s.br = 1; s.tk = 0;
        step(s);
        s = idle(); s.exr = 1; s.exw = 1; s.exd = 10; s.br = 1; s.rt = 10; s.urt = 1;
        step(s);
        s = idle(); s.rst_n = 0; s.exr = 1; s.exd = 3; s.rs = 3; s.urs = 1;
        step(s);
        s = idle(); step(s); step(s);
        s = idle(); s.exr = 1; s.exd = 5; s.rs = 5; s.urs = 1;
        for (int i = 0; i < 20; i++) step(s);
        s = idle(); step(s);
        for (int i = 0; i < 2000; i++) begin
            s.rst_n = $urandom_range(0, 63) != 0;
            s.rs = AW'($urandom_range(0, 3)); s.rt = AW'($urandom_range(0, 3));
            s.exd = AW'($urandom_range(0, 3)); s.memd = AW'($urandom_range(0, 3));
            s.urs = 1'($urandom); s.urt = 1'($urandom); s.br = 1'($urandom);
            s.jp = $urandom_range(0, 3) == 0; s.tk = 1'($urandom);
            s.exr = $urandom_range(0, 3) == 0; s.exw = 1'($urandom);
            s.memr = $urandom_range(0, 3) == 0; s.memw = 1'($urandom);
            step(s);
        end
        w = 0;
        while (q.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never compared, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
